// File: rtl/alu_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_queue
// Purpose  : Request FIFO, registered issue stage (S1) and result register
//            (S2) feeding a 2-bit combinational ALU. Keeps saturating counts
//            of failed (ok=0) and overflowed results.
// Ports    : clk, rst            - clock, asynchronous active-high reset
//            in_valid/in_ready   - request handshake; in_ready = !full
//            in_instr, in_data*  - request payload
//            instruction, data*  - registered operands to the ALU
//            alu_*               - combinational ALU response
//            res_valid/res_ready - result handshake
//            res_*               - captured ALU response
//            err_count/ovf_count - saturating statistics
//            busy                - any work queued or in flight
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    // request side
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_instr,
    input  logic [1:0]       in_data0,
    input  logic [1:0]       in_data1,
    // ALU-facing operands
    output logic [7:0]       instruction,
    output logic [1:0]       data0,
    output logic [1:0]       data1,
    // ALU response
    input  logic             alu_ok,
    input  logic             alu_ovf,
    input  logic [1:0]       alu_out0,
    input  logic [1:0]       alu_out1,
    input  logic [7:0]       alu_instr_out,
    // result side
    output logic             res_valid,
    input  logic             res_ready,
    output logic [7:0]       res_instr,
    output logic [1:0]       res_out0,
    output logic [1:0]       res_out1,
    output logic             res_ok,
    output logic             res_ovf,
    // statistics / status
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] ovf_count,
    output logic             busy
);

    localparam int                c_ADDR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int                c_ENTRY_W = 12;
    localparam logic [c_ADDR_W:0] c_FULL    = (c_ADDR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  c_CNT_MAX = {CNT_W{1'b1}};

    // FIFO storage and pointers
    logic [c_ENTRY_W-1:0] r_mem [DEPTH];
    logic [c_ADDR_W-1:0]  r_wptr;
    logic [c_ADDR_W-1:0]  r_rptr;
    logic [c_ADDR_W:0]    r_count;

    // S1 issue register
    logic                 r_s1_valid;
    logic [7:0]           r_instruction;
    logic [1:0]           r_data0;
    logic [1:0]           r_data1;

    // S2 result register
    logic                 r_res_valid;
    logic [7:0]           r_res_instr;
    logic [1:0]           r_res_out0;
    logic [1:0]           r_res_out1;
    logic                 r_res_ok;
    logic                 r_res_ovf;

    logic [CNT_W-1:0]     r_err_count;
    logic [CNT_W-1:0]     r_ovf_count;

    logic                 w_full;
    logic                 w_empty;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_s2_free;
    logic                 w_s1_adv;
    logic                 w_s1_can_load;

    // Ready depends only on the registered count, so a pop in the same cycle
    // never opens a combinational path from res_ready to in_ready.
    assign w_full        = (r_count == c_FULL);
    assign w_empty       = (r_count == '0);
    assign w_push        = in_valid && !w_full;
    assign w_s2_free     = !r_res_valid || res_ready;
    assign w_s1_adv      = r_s1_valid && w_s2_free;
    assign w_s1_can_load = !r_s1_valid || w_s1_adv;
    assign w_pop         = !w_empty && w_s1_can_load;

    // Storage is not reset: entries are only observable through the count.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= {in_instr, in_data0, in_data1};
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + c_ADDR_W'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + c_ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_ADDR_W + 1)'(1);
                2'b01:   r_count <= r_count - (c_ADDR_W + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // S1: loads on a pop; when it drains without a refill the ALU is given
    // an all-zero idle op so its inputs do not carry a stale request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid    <= 1'b0;
            r_instruction <= 8'h00;
            r_data0       <= 2'd0;
            r_data1       <= 2'd0;
        end else if (w_pop) begin
            r_s1_valid                         <= 1'b1;
            {r_instruction, r_data0, r_data1}  <= r_mem[r_rptr];
        end else if (w_s1_adv) begin
            r_s1_valid    <= 1'b0;
            r_instruction <= 8'h00;
            r_data0       <= 2'd0;
            r_data1       <= 2'd0;
        end
    end

    // S2: captures the ALU response for the op currently held in S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_res_valid <= 1'b0;
            r_res_instr <= 8'h00;
            r_res_out0  <= 2'd0;
            r_res_out1  <= 2'd0;
            r_res_ok    <= 1'b0;
            r_res_ovf   <= 1'b0;
        end else if (w_s1_adv) begin
            r_res_valid <= 1'b1;
            r_res_instr <= alu_instr_out;
            r_res_out0  <= alu_out0;
            r_res_out1  <= alu_out1;
            r_res_ok    <= alu_ok;
            r_res_ovf   <= alu_ovf;
        end else if (res_ready) begin
            r_res_valid <= 1'b0;
        end
    end

    // Counters step only on a definite 0/1 status; an unknown status leaves
    // them untouched because the comparisons below are not true for X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_count <= '0;
            r_ovf_count <= '0;
        end else if (w_s1_adv) begin
            if ((alu_ok == 1'b0) && (r_err_count != c_CNT_MAX)) begin
                r_err_count <= r_err_count + CNT_W'(1);
            end
            if ((alu_ovf == 1'b1) && (r_ovf_count != c_CNT_MAX)) begin
                r_ovf_count <= r_ovf_count + CNT_W'(1);
            end
        end
    end

    assign in_ready    = !w_full;
    assign instruction = r_instruction;
    assign data0       = r_data0;
    assign data1       = r_data1;
    assign res_valid   = r_res_valid;
    assign res_instr   = r_res_instr;
    assign res_out0    = r_res_out0;
    assign res_out1    = r_res_out1;
    assign res_ok      = r_res_ok;
    assign res_ovf     = r_res_ovf;
    assign err_count   = r_err_count;
    assign ovf_count   = r_ovf_count;
    assign busy        = !w_empty || r_s1_valid || r_res_valid;

endmodule
`default_nettype wire

// File: doc/alu_issue_queue.md
# alu_issue_queue

Upstream feeder for the 2-bit ALU `TOP`. It buffers operation requests ({instruction, data0, data1}) in a small FIFO and issues them to the ALU one per cycle through a registered operand stage. It captures the ALU's combinational response (ok, ovf, out0, out1, instr_out) into a result register with a valid/ready handshake. It also keeps saturating counters of rejected and overflowed operations.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of the statistics counters.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: request present.
- `in_ready` out 1: FIFO can accept; equals !full.
- `in_instr` in 8: instruction opcode.
- `in_data0`, `in_data1` in 2 each: operands.
- `instruction` out 8: to ALU, registered.
- `data0`, `data1` out 2 each: to ALU, registered.
- `alu_ok`, `alu_ovf` in 1 each: ALU status, combinational from the issued operands.
- `alu_out0`, `alu_out1` in 2 each: ALU results.
- `alu_instr_out` in 8: ALU instruction echo.
- `res_valid` out 1: result register holds a result.
- `res_ready` in 1: consumer accepts the result.
- `res_instr` out 8: captured `alu_instr_out`.
- `res_out0`, `res_out1` out 2 each: captured results.
- `res_ok`, `res_ovf` out 1 each: captured status.
- `err_count` out CNT_W: results with ok=0; saturating.
- `ovf_count` out CNT_W: results with ovf=1; saturating.
- `busy` out 1: FIFO non-empty, or S1 valid, or res_valid.

## Operation
- FIFO: DEPTH × 12-bit entries; write pointer, read pointer, and a count of width log2(DEPTH)+1. Pointers wrap modulo DEPTH.
- Push when in_valid && in_ready. Pop when the FIFO is non-empty && S1 can load.
- S1 (issue register): holds s1_valid plus {instruction, data0, data1}.
  - S1 loads on a pop.
  - When S1 empties without a pop, its outputs are driven to instruction=8'h00, data0=0, data1=0. The ALU then sees a benign idle op.
- S2 (result register) is the res_* outputs.
  - s2_free = !res_valid || res_ready.
  - s1_adv = s1_valid && s2_free.
  - On s1_adv, S2 captures alu_* and res_valid ← 1. Otherwise, if res_ready, res_valid ← 0.
- S1 can load when !s1_valid || s1_adv.
- Counters update only on s1_adv:
  - err_count += 1 when alu_ok=0.
  - ovf_count += 1 when alu_ovf=1.
  - Both hold at 2^CNT_W−1.
- An instruction containing X/Z bits is passed through unchanged. Its ok/ovf are captured as delivered by the ALU, and no counter increments on X.
- Reset state, asynchronous: FIFO empty, pointers 0, in_ready=1, all ALU-facing outputs 0, s1_valid=0, res_valid=0, all res_* 0, counters 0, busy=0.
- Reset mid-operation discards every FIFO entry and in-flight result immediately. No result is emitted for them.

## Timing
- Empty pipeline: a push accepted at edge N is popped at edge N+1, so operands appear at the ALU after N+1. The result is captured at edge N+2, so res_valid=1 after N+2. Push-to-result latency is 2 cycles.
- Throughput is 1 op/cycle while res_ready=1.
- res_ready=0 with res_valid=1: S2 holds and S1 holds, so ALU inputs stay stable. The FIFO keeps accepting until full, then in_ready=0.
- Push and pop in the same cycle: count is unchanged. This is allowed at any non-full count.
- Full FIFO: in_ready=0 even if a pop occurs in that cycle. There is no combinational ready path.
- Empty FIFO with S1 draining: S1 clears on the same edge as the S2 capture.
- res_* outputs are stable while res_valid && !res_ready.

## Test plan
- Reset, then push {02,1,1}: instruction=8'h02, data0=1, data1=1 one cycle after the push. Two cycles after the push, res_valid=1 and res_* equal the ALU response to that op.
- Push 4 ops with res_ready=0: two edges after the first push, the first result is in S2. One edge later, S1 holds the second op and the FIFO refills; after 6 pushes the FIFO holds 4 and in_ready=0. Raise res_ready: results drain in push order, one per cycle.
- Stream all 16 {00,d0,d1} combinations back-to-back with res_ready=1: 16 results in order at 1/cycle. ovf_count and err_count equal the ALU's ovf=1 and ok=0 totals.
- Issue op f0 with d0=3, d1=0, where the ALU flags ok=0: err_count increments by 1. Preset the count to 255, issue another: it stays at 255.
- Assert rst while the FIFO is at 3 and res_valid=1: all outputs are 0 and in_ready=1 immediately, asynchronously. After release, no stale result appears.
- Push on the same edge as a pop at count=2: count stays 2 and entry order is preserved.
